huffman_symbol_buffer: RTL
==========================

# huffman_symbol_buffer

Downstream stage of the serial Huffman decoder. It samples the decoder's 3-bit symbol output every clock, treating 0 as "no symbol" and 1..6 as decoded symbols. Each valid symbol is queued in a small show-ahead FIFO that a consumer drains with a valid/ready handshake. The block also keeps a saturating accepted-symbol counter and sticky overflow and illegal-code flags for status readout.

## Interface
- DEPTH, 8: FIFO entries; power of two, at least 2.
- CNT_W, 16: width of the accepted-symbol counter.
- AW, log2(DEPTH): derived address width; not overridden.

- clk  input  1  clock; all state updates on posedge.
- reset  input  1  reset, asynchronous, active-high.
- sym_in  input  3  decoder symbol: 0 = idle, 1..6 = symbol, 7 = illegal.
- clr  input  1  synchronous clear of sym_total, overflow and illegal; FIFO contents untouched.
- out_data  output  3  head-of-FIFO symbol; 0 when empty.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready at posedge.
- level  output  AW+1  current occupancy, 0..DEPTH.
- sym_total  output  CNT_W  count of symbols written into the FIFO; saturates at all-ones.
- overflow  output  1  sticky: a valid symbol was dropped because the FIFO was full.
- illegal  output  1  sticky: sym_in == 7 was seen.

## Operation
- Reset (asynchronous) sets out_valid=0, out_data=0, level=0, sym_total=0, overflow=0, illegal=0, and both pointers to 0.
- The block samples sym_in every posedge; there is no input handshake.
- sym_in == 0: no action.
- sym_in in 1..6 is a write request:
  - Accepted if level < DEPTH, or if level == DEPTH and a read fires in the same cycle.
  - Otherwise the symbol is dropped and overflow is set.
- sym_in == 7: never written; illegal is set.
- Read fires when out_valid && out_ready. It advances rd_ptr and decrements level.
- Simultaneous write and read:
  - level is unchanged; both pointers advance.
  - When full, the write goes into the slot freed by the read.
- Pointers are AW bits wide and wrap modulo DEPTH. Full and empty are derived from level.
- out_data is mem[rd_ptr] when level > 0 (show-ahead), and 0 otherwise.
- sym_total increments by 1 per accepted write and holds at 2^CNT_W-1.
- clr has priority over same-cycle events:
  - sym_total becomes 0 and both flags become 0, even if an overflow or illegal event, or a write, occurs that cycle.
  - A write in the clr cycle still enters the FIFO.
- A read issued while out_valid=0 is ignored.

## Timing
- Write latency is 1 cycle: a symbol on sym_in at edge N appears on out_data/out_valid after edge N, so it is readable at edge N+1.
- Full throughput is one write and one read per cycle. The decoder emits at most one symbol per cycle (≥1 idle between symbols in practice), so overflow occurs only under consumer backpressure.
- level, flags and sym_total are registered and update at the same edge as the triggering event.
- out_valid and out_data have no combinational path from sym_in. They also have no combinational path from out_ready; out_ready affects only the next state.
- Reset mid-operation empties the FIFO immediately (asynchronous). Buffered symbols are lost; out_valid drops without waiting for a clock.

## Test plan
- **Basic flow:** reset, then sym_in sequence 1,0,2,0,6 with out_ready=0 → level=3, out_data=1, sym_total=3. Then out_ready=1 → out_data reads 1,2,6 on successive edges, then out_valid=0 and out_data=0.
- **Overflow:** out_ready=0, write 9 symbols of value 3 → level=8, sym_total=8, overflow=1, and the 9th is not stored. Draining yields exactly eight 3s.
- **Full with simultaneous read:** fill to 8 with 1..6,1,2. Next cycle write 5 with out_ready=1 → overflow stays 0, level stays 8. Draining gives 2,3,4,5,6,1,2,5 (wrap-around verified).
- **Illegal and clear:** sym_in=7 → illegal=1, level unchanged. clr=1 with sym_in=4 in the same cycle → illegal=0, sym_total=0, level incremented by 1, out_data shows 4 at the head once earlier entries drain.
- **Saturation:** CNT_W=3, out_ready=1, 10 writes of symbol 1 → sym_total ends at 7 and never wraps.
- **Async reset mid-stream:** level=5, then assert reset between edges → out_valid=0, level=0 and all outputs 0 before the next posedge. After release, the first write appears normally.

Source files
------------

// File: rtl/huffman_symbol_buffer.sv
`default_nettype none
// ============================================================================
// Module   : huffman_symbol_buffer
// Purpose  : Output stage of the serial Huffman decoder. Samples the 3-bit
//            decoder symbol every clock, queues symbols 1..6 in a small
//            show-ahead FIFO drained by a valid/ready consumer, and keeps a
//            saturating accepted-symbol counter plus sticky overflow and
//            illegal-code status flags.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1       clock, all state updates on the rising edge
//   reset      in   1       asynchronous active-high reset
//   sym_in     in   3       0 = idle, 1..6 = symbol, 7 = illegal code
//   clr        in   1       synchronous clear of sym_total / overflow / illegal
//   out_data   out  3       head-of-FIFO symbol, 0 when empty
//   out_valid  out  1       FIFO holds at least one symbol
//   out_ready  in   1       consumer takes out_data at the edge when valid
//   level      out  AW+1    occupancy, 0..DEPTH
//   sym_total  out  CNT_W   symbols written into the FIFO, saturating
//   overflow   out  1       sticky: a symbol was dropped on a full FIFO
//   illegal    out  1       sticky: code 7 was observed on sym_in
// ============================================================================
module huffman_symbol_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   sym_in,
  input  logic                         clr,
  output logic [2:0]                   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH):0]       level,
  output logic [CNT_W-1:0]             sym_total,
  output logic                         overflow,
  output logic                         illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]    C_FULL_LEVEL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [2:0]       C_SYM_IDLE   = 3'd0;
  localparam logic [2:0]       C_SYM_ILLEGAL = 3'd7;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]       mem_q [DEPTH];
  logic [2:0]       mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] sym_total_q, sym_total_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;

  // --------------------------------------------------------------------------
  // Event decode
  // --------------------------------------------------------------------------
  logic w_is_sym;
  logic w_is_illegal;
  logic w_empty;
  logic w_full;
  logic w_rd_fire;
  logic w_wr_fire;
  logic w_drop;

  assign w_is_sym     = (sym_in != C_SYM_IDLE) && (sym_in != C_SYM_ILLEGAL);
  assign w_is_illegal = (sym_in == C_SYM_ILLEGAL);
  assign w_empty      = (level_q == '0);
  assign w_full       = (level_q == C_FULL_LEVEL);

  // A read only counts when data is actually present; out_ready alone is
  // ignored on an empty FIFO.
  assign w_rd_fire = !w_empty && out_ready;

  // On a full FIFO the write may reuse the slot being freed by a
  // same-cycle read, so full-throughput streaming never drops symbols.
  assign w_wr_fire = w_is_sym && (!w_full || w_rd_fire);
  assign w_drop    = w_is_sym && !w_wr_fire;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (w_wr_fire) begin
      mem_d[wr_ptr_q] = sym_in;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    if (w_wr_fire) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (w_rd_fire) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (w_wr_fire && !w_rd_fire) begin
      level_d = level_q + LW'(1);
    end else if (w_rd_fire && !w_wr_fire) begin
      level_d = level_q - LW'(1);
    end
  end

  always_comb begin
    sym_total_d = sym_total_q;
    overflow_d  = overflow_q;
    illegal_d   = illegal_q;

    // clr wins over any same-cycle status event; the FIFO path above is
    // independent of clr, so a write in the clear cycle is still stored.
    if (clr) begin
      sym_total_d = '0;
      overflow_d  = 1'b0;
      illegal_d   = 1'b0;
    end else begin
      if (w_wr_fire && (sym_total_q != C_CNT_MAX)) begin
        sym_total_d = sym_total_q + CNT_W'(1);
      end
      if (w_drop) begin
        overflow_d = 1'b1;
      end
      if (w_is_illegal) begin
        illegal_d = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // Storage is not reset: out_data is masked by level, so stale contents
  // are never visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      sym_total_q <= '0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      sym_total_q <= sym_total_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs - driven only from registers, so no path from sym_in/out_ready.
  // --------------------------------------------------------------------------
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? 3'd0 : mem_q[rd_ptr_q];
  assign level     = level_q;
  assign sym_total = sym_total_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;

endmodule
`default_nettype wire
